// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared types and default sizing for the multiport register file.
//   rf_state_t      : clear-sequencer state (INIT clears the array, RUN is normal use)
//   REGFILE_DATA_W  : default register width
//   REGFILE_ADDR_W  : default register address width
package regfile_pkg;

   localparam int REGFILE_DATA_W = 32;
   localparam int REGFILE_ADDR_W = 5;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } rf_state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq -- post-reset clear sequencer for regfile_multiport.
// Walks clr_idx from 0 to DEPTH-1 (one entry per clock) while in INIT, then
// parks in RUN until the next reset.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   busy       : registered, 1 while the clear is in progress
//   clr_we     : clear write enable into the storage array
//   clr_addr   : entry being cleared this cycle
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int ADDR_W = REGFILE_ADDR_W,
   parameter int DEPTH  = 2 ** ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   rf_state_t         state;
   logic [ADDR_W-1:0] clr_idx;

   // clr_idx saturates at LAST_IDX; the leaving edge is the one that clears it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= INIT;
         clr_idx <= '0;
         busy    <= 1'b1;
      end else begin
         case (state)
            INIT: begin
               if (clr_idx == LAST_IDX) begin
                  state <= RUN;
                  busy  <= 1'b0;
               end else begin
                  clr_idx <= clr_idx + 1'b1;
               end
            end
            default: begin
               state <= RUN;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign clr_we   = (state == INIT);
   assign clr_addr = clr_idx;

endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport -- 1-write / 2-read register file with post-reset clear.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   rd_addr_a / rd_data_a  : read port A (combinational)
//   rd_addr_b / rd_data_b  : read port B (combinational)
//   wr_en, wr_addr, wr_data: write port (rising edge)
//   busy                   : clear in progress; writes ignored, reads return 0
// Option macro REGFILE_BYPASS_EN: forward same-cycle write data to a read port
// addressing the register being written.
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter int DATA_W   = REGFILE_DATA_W,
   parameter int ADDR_W   = REGFILE_ADDR_W,
   parameter int DEPTH    = 2 ** ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              busy
);

   localparam int              NPORTS  = 2;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < DEPTH_C;
   endfunction

   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              wr_ok;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [NPORTS-1:0][ADDR_W-1:0] raddr;
   logic [NPORTS-1:0][DATA_W-1:0] rdata;

   regfile_clear_seq #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_clear_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   // A reset edge must not also commit a user write, hence the rst_n term.
   assign wr_ok = rst_n && wr_en && !busy && in_range(wr_addr) && !is_zero_reg(wr_addr);

   // clr_we and wr_ok never overlap: wr_ok requires !busy, clr_we implies busy.
   always_ff @(posedge clk) begin
      if (clr_we)
         mem[clr_addr] <= '0;
      else if (wr_ok)
         mem[wr_addr] <= wr_data;
   end

   assign raddr = {rd_addr_b, rd_addr_a};

   always_comb begin
      rdata = '0;
      for (int p = 0; p < NPORTS; p++) begin
         if (!busy && in_range(raddr[p]) && !is_zero_reg(raddr[p])) begin
            rdata[p] = mem[raddr[p]];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (wr_addr == raddr[p]))
               rdata[p] = wr_data;
`endif
         end
      end
   end

   assign rd_data_a = rdata[0];
   assign rd_data_b = rdata[1];

endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport -- self-checking bench for regfile_multiport.
// Three instances share one stimulus stream: defaults, ZERO_REG=0, DEPTH=20.
// A per-instance reference model (plain register array + remaining-clear count)
// predicts busy and both read ports every cycle.
module tb_regfile_multiport;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rd_addr_a, rd_addr_b, wr_addr;
   logic        wr_en;
   logic [31:0] wr_data;

   logic        busy [3];
   logic [31:0] rda  [3];
   logic [31:0] rdb  [3];

   int checks = 0;
   int errors = 0;
   bit started = 0;

   int          dep  [3] = '{32, 32, 20};
   int          zr   [3] = '{1, 0, 1};
   int          bleft[3];
   logic [31:0] mreg [3][32];

   always #5 clk = ~clk;

   regfile_multiport dut0 (
      .clk(clk), .rst_n(rst_n), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rda[0]), .rd_data_b(rdb[0]), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy[0]));

   regfile_multiport #(.ZERO_REG(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rda[1]), .rd_data_b(rdb[1]), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy[1]));

   regfile_multiport #(.DEPTH(20)) dut2 (
      .clk(clk), .rst_n(rst_n), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rda[2]), .rd_data_b(rdb[2]), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy[2]));

   // ---------------- reference model ----------------
   function automatic bit m_wvalid(input int k);
      return rst_n && wr_en && (bleft[k] == 0) && (int'(wr_addr) < dep[k])
             && !(zr[k] != 0 && wr_addr == 5'd0);
   endfunction

   function automatic logic [31:0] m_read(input int k, input logic [4:0] a);
      if (bleft[k] > 0) return 32'h0;
      if (int'(a) >= dep[k]) return 32'h0;
      if (zr[k] != 0 && a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (m_wvalid(k) && wr_addr == a) return wr_data;
`endif
      return mreg[k][a];
   endfunction

   // Clear takes DEPTH clocks once reset is released; contents are all-zero after it.
   task automatic m_clock();
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            bleft[k] = dep[k];
            for (int i = 0; i < 32; i++) mreg[k][i] = 32'h0;
         end else if (bleft[k] > 0) begin
            bleft[k]--;
         end else if (m_wvalid(k)) begin
            mreg[k][wr_addr] = wr_data;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive after the falling edge, check mid-low phase, advance model at the rising edge.
   task automatic step(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
      @(negedge clk);
      rst_n = r; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
      #1;
      if (started) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("busy[%0d]", k), {31'b0, busy[k]}, {31'b0, bleft[k] > 0});
            chk($sformatf("rda[%0d] a=%0d", k, ra), rda[k], m_read(k, ra));
            chk($sformatf("rdb[%0d] a=%0d", k, rb), rdb[k], m_read(k, rb));
         end
      end
      @(posedge clk);
      m_clock();
      started = 1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b1, 1'b0, 5'd0, 32'h0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
   endtask

   task automatic read_all();
      for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [4:0] ra);
      step(1'b1, 1'b1, a, d, ra, a);
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;

      // Reset for 2 cycles, then the clear sequence; busy tracked every cycle.
      step(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
      step(1'b0, 1'b1, 5'd4, 32'h1111, 5'd4, 5'd0);
      idle(34);
      read_all();

      // Write/read on both ports, same register.
      wr(5'd5, 32'hDEADBEEF, 5'd5);
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);

      // Register 0: hardwired on dut0/dut2, ordinary on dut1.
      wr(5'd0, 32'h12345678, 5'd1);
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

      // Same-cycle write/read of r7 (bypass behaviour follows the macro).
      wr(5'd7, 32'h1, 5'd0);
      wr(5'd7, 32'hA5A5A5A5, 5'd7);
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);

      // Out-of-range write (dut2 has 20 entries).
      wr(5'd25, 32'h55, 5'd25);
      wr(5'd19, 32'h1919, 5'd19);
      read_all();

      // Last write wins on back-to-back writes.
      wr(5'd9, 32'hAAAA0001, 5'd9);
      wr(5'd9, 32'hBBBB0002, 5'd9);
      wr(5'd9, 32'hCCCC0003, 5'd9);
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);

      // Randomized traffic.
      for (int i = 0; i < 200; i++)
         step(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      read_all();

      // Reset in RUN, write during INIT, reset again mid-INIT.
      step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd5);
      for (int k = 0; k < 10; k++)
         step(1'b1, k == 4, 5'd3, 32'hFF, 5'd3, 5'd5);
      step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
      idle(34);
      read_all();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register address width.
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_W, meaning the number of implemented registers, legal range 2..2**ADDR_W.
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning that register 0 is hardwired to zero when set to 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have ports rd_addr_a and rd_addr_b, inputs, ADDR_W bits: read port A/B address.
REQ-008 SHALL have ports rd_data_a and rd_data_b, outputs, DATA_W bits: read port A/B data.
REQ-009 SHALL have port wr_en, input, 1 bit: write request.
REQ-010 SHALL have port wr_addr, input, ADDR_W bits: write address.
REQ-011 SHALL have port wr_data, input, DATA_W bits: write data.
REQ-012 SHALL have port busy, output, 1 bit: the clear sequence is in progress, and writes are ignored while it is set.

Function
REQ-013 SHALL implement a two-state FSM, INIT and RUN, plus a clear counter clr_idx of ADDR_W bits.
REQ-014 INIT: SHALL write 0 to register[clr_idx] and increment clr_idx by one entry per cycle.
REQ-015 INIT: SHALL move to RUN on the cycle that clears entry DEPTH-1, so INIT lasts exactly DEPTH cycles after rst_n deasserts.
REQ-016 RUN: SHALL stay in RUN until the next reset.
REQ-017 busy SHALL be 1 in INIT and 0 in RUN.
REQ-018 Reads SHALL be combinational, with zero-cycle latency from address to data.
REQ-019 While busy=1, rd_data_a and rd_data_b SHALL read 0.
REQ-020 A write SHALL update the register on the rising clk edge when wr_en=1, busy=0 and wr_addr<DEPTH.
REQ-021 With ZERO_REG=1, a write to address 0 SHALL be discarded and reads of address 0 SHALL return 0.
REQ-022 A read of an address >= DEPTH SHALL return 0.
REQ-023 A write to an address >= DEPTH SHALL be ignored.
REQ-024 Both read ports SHALL be independent and may address the same register; each then returns the same value.
REQ-025 A write of the same address on consecutive cycles SHALL be last-write-wins.
REQ-026 clr_idx SHALL NOT wrap: it saturates at DEPTH-1 and holds once in RUN.

Reset
REQ-027 When rst_n=0 at a rising edge, the block SHALL set FSM=INIT and clr_idx=0; busy SHALL read 1 and rd_data_a/rd_data_b SHALL read 0 from the following cycle.
REQ-028 Reset asserted mid-INIT SHALL restart the clear from entry 0.
REQ-029 Reset asserted in RUN SHALL re-enter INIT, and all registers SHALL read 0 once INIT completes.
REQ-030 No register contents SHALL be loaded from a file; the power-up contents are defined only by the clear sequence.

Configuration
REQ-031 The block SHALL have one compile-time option, macro REGFILE_BYPASS_EN.
REQ-032 With REGFILE_BYPASS_EN defined: in RUN, when wr_en=1 and wr_addr equals a read address (nonzero if ZERO_REG, and < DEPTH), that read port SHALL return wr_data in the same cycle (write-to-read forwarding).
REQ-033 Without REGFILE_BYPASS_EN: the read port SHALL return the pre-write value in that cycle and the new value from the next cycle.

Structure
REQ-034 A shared package regfile_pkg SHALL hold the FSM state typedef (INIT, RUN) and default constants REGFILE_DATA_W=32 and REGFILE_ADDR_W=5.
REQ-035 The block SHALL have one sub-module, regfile_clear_seq, containing the FSM, clr_idx and busy, and driving the clear write enable and address into the storage array.
REQ-036 Storage and read muxes SHALL stay in regfile_multiport.

Verification
REQ-037 Reset and clear: hold rst_n=0 for 2 cycles, then release with defaults -> busy=1 for exactly 32 cycles, then 0; all 32 registers then read 0.
REQ-038 Write/read: write 0xDEADBEEF to r5, then read r5 on port A and r5 on port B next cycle -> both ports return 0xDEADBEEF.
REQ-039 Zero register: write 0x12345678 to r0 -> r0 still reads 0. With ZERO_REG=0, the same write -> r0 reads 0x12345678.
REQ-040 Bypass: same cycle wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5 and rd_addr_a=7, with r7 previously 0x1 -> rd_data_a=0xA5A5A5A5 when REGFILE_BYPASS_EN is defined, 0x1 when it is not.
REQ-041 Busy-write and reset mid-INIT: write r3=0xFF at INIT cycle 4 and pulse rst_n=0 at INIT cycle 10 -> INIT restarts at entry 0, busy lasts 32 more cycles, r3 reads 0.
REQ-042 Out of range: DEPTH=20, write 0x55 to address 25 -> ignored; reading address 25 returns 0, and r0..r19 are unchanged.
